dram_arb: RTL and testbench

// - Arbitrates one single-port data RAM between two requesters: the CPU data port (cpu_*) and the UART host loader (host_*).
// - Sits between the core/loader and the RAM macro. Issues at most one access per cycle, with bounded-burst round-robin fairness.
// - Routes the 1-cycle-latency RAM read data back to the requester that issued the read.

---
 rtl/dram_arb_pkg.sv | 28 ++
 rtl/dram_arb_if.sv | 16 +
 rtl/dram_arb_pick.sv | 46 ++++
 rtl/dram_arb.sv | 118 +++++++++++
 tb/tb_dram_arb.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_arb_pkg.sv
// Shared types for the data-RAM arbiter: owner/read-tag encodings and the muxed request bundle.
package dram_arb_pkg;

  localparam int DRAM_XLEN = 32;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_HOST = 2'd2
  } rd_tag_t;

  typedef struct packed {
    logic                 we;
    logic [DRAM_XLEN-1:0] addr;
    logic [DRAM_XLEN-1:0] wdata;
    logic [3:0]           be;
  } dram_req_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_CPU) ? OWN_HOST : OWN_CPU;
  endfunction

endpackage

// File: rtl/dram_arb_if.sv
// One requester port of the data-RAM arbiter (CPU data port or UART host loader).
interface dram_arb_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      be;
  logic            gnt;
  logic            rvld;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvld, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvld, rdata);
endinterface

// File: rtl/dram_arb_pick.sv
// Combinational bounded-burst round-robin grant decision plus next owner/burst count.
module dram_arb_pick
  import dram_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CW        = $clog2(MAX_BURST + 1)
) (
  input  logic          cpu_req,
  input  logic          host_req,
  input  owner_t        owner,
  input  logic [CW-1:0] burst_cnt,
  output logic          cpu_gnt,
  output logic          host_gnt,
  output owner_t        owner_nxt,
  output logic [CW-1:0] cnt_nxt
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  owner_t winner;
  logic   any_req;

  always_comb begin
    any_req   = cpu_req || host_req;
    owner_nxt = owner;
    cnt_nxt   = burst_cnt;
    if (cpu_req && host_req) begin
      winner = (burst_cnt < CNT_MAX) ? owner : other_owner(owner);
    end else begin
      winner = cpu_req ? OWN_CPU : OWN_HOST;
    end
    // A lone requester saturates the count so a later contender waits at most MAX_BURST grants.
    if (any_req) begin
      owner_nxt = winner;
      if (winner != owner) begin
        cnt_nxt = CNT_ONE;
      end else if (burst_cnt < CNT_MAX) begin
        cnt_nxt = burst_cnt + CNT_ONE;
      end
    end
    cpu_gnt  = any_req && (winner == OWN_CPU);
    host_gnt = any_req && (winner == OWN_HOST);
  end

endmodule

// File: rtl/dram_arb.sv
// Single-port data-RAM arbiter between CPU and host loader with 1-cycle read-return routing.
// Optional DRAM_ARB_RANGE_CHECK_EN: suppresses out-of-range RAM accesses and raises a sticky err_o.
//
// owner    | meaning
// OWN_CPU  | CPU wins ties until its burst count reaches MAX_BURST
// OWN_HOST | host wins ties until its burst count reaches MAX_BURST
module dram_arb
  import dram_arb_pkg::*;
#(
  parameter int XLEN      = DRAM_XLEN,
  parameter int AW        = 14,
  parameter int MAX_BURST = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dram_arb_if.slave       cpu,
  dram_arb_if.slave       host,
  output logic            ram_en_o,
  output logic [3:0]      ram_we_o,
  output logic [AW-1:0]   ram_addr_o,
  output logic [XLEN-1:0] ram_wdata_o,
  input  logic [XLEN-1:0] ram_rdata_i,
  output logic            err_o
);

  localparam int CW = $clog2(MAX_BURST + 1);

  owner_t          owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  rd_tag_t         rd_tag_q, rd_tag_d;
  logic            rd_oor_q, rd_oor_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [XLEN-1:0] host_rdata_q, host_rdata_d;
  logic [XLEN-1:0] ret_data;
  logic            cpu_gnt, host_gnt, gnt_any, oor;
  dram_req_t       sel;

  dram_arb_pick #(
    .MAX_BURST (MAX_BURST),
    .CW        (CW)
  ) u_pick (
    .cpu_req   (cpu.req && !rst_i),
    .host_req  (host.req && !rst_i),
    .owner     (owner_q),
    .burst_cnt (cnt_q),
    .cpu_gnt   (cpu_gnt),
    .host_gnt  (host_gnt),
    .owner_nxt (owner_d),
    .cnt_nxt   (cnt_d)
  );

  always_comb begin
    sel = '0;
    if (cpu_gnt) begin
      sel = '{we: cpu.we, addr: cpu.addr, wdata: cpu.wdata, be: cpu.be};
    end else if (host_gnt) begin
      sel = '{we: host.we, addr: host.addr, wdata: host.wdata, be: host.be};
    end
    gnt_any = cpu_gnt || host_gnt;
`ifdef DRAM_ARB_RANGE_CHECK_EN
    oor   = gnt_any && (sel.addr[XLEN-1:AW+2] != '0);
    err_d = err_q || oor;
`else
    oor   = 1'b0;
    err_d = 1'b0;
`endif
    ram_en_o    = gnt_any && !oor;
    ram_we_o    = (ram_en_o && sel.we) ? sel.be : 4'h0;
    ram_addr_o  = ram_en_o ? sel.addr[AW+1:2] : '0;
    ram_wdata_o = ram_en_o ? sel.wdata : '0;

    rd_tag_d = TAG_NONE;
    if (cpu_gnt && !sel.we) begin
      rd_tag_d = TAG_CPU;
    end else if (host_gnt && !sel.we) begin
      rd_tag_d = TAG_HOST;
    end
    rd_oor_d = oor && !sel.we;

    // Suppressed reads still return a beat, forced to zero instead of stale RAM output.
    ret_data     = rd_oor_q ? '0 : ram_rdata_i;
    cpu.rvld     = (rd_tag_q == TAG_CPU) && !rst_i;
    host.rvld    = (rd_tag_q == TAG_HOST) && !rst_i;
    cpu_rdata_d  = cpu.rvld ? ret_data : cpu_rdata_q;
    host_rdata_d = host.rvld ? ret_data : host_rdata_q;
  end

  assign cpu.gnt    = cpu_gnt;
  assign host.gnt   = host_gnt;
  assign cpu.rdata  = cpu_rdata_d;
  assign host.rdata = host_rdata_d;
  assign err_o      = err_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{sel.addr[1:0], sel.addr[XLEN-1:AW+2]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q      <= OWN_CPU;
      cnt_q        <= '0;
      rd_tag_q     <= TAG_NONE;
      rd_oor_q     <= 1'b0;
      err_q        <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      rd_tag_q     <= rd_tag_d;
      rd_oor_q     <= rd_oor_d;
      err_q        <= err_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

endmodule

// File: tb/tb_dram_arb.sv
// Bench for dram_arb: directed arbitration sequences with a read-return scoreboard and RAM model.
module tb_dram_arb;

  localparam int AW = 14;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        err;

  dram_arb_if #(.XLEN(32)) cpu_if ();
  dram_arb_if #(.XLEN(32)) host_if ();

  dram_arb #(.XLEN(32), .AW(AW), .MAX_BURST(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cpu         (cpu_if),
    .host        (host_if),
    .ram_en_o    (ram_en),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // RAM macro: read-first, 1-cycle latency
  logic [31:0] mem [0:(1<<AW)-1] = '{default: '0};
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      ram_rdata <= mem[ram_addr];
    end
  end

  // reference contents as seen by the requesters
  logic [31:0] shadow [0:(1<<AW)-1] = '{default: '0};

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef DRAM_ARB_RANGE_CHECK_EN
    return a[31:AW+2] != '0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    if (out_of_range(a)) return 32'h0;
    return shadow[a[AW+1:2]];
  endfunction

  function automatic void shadow_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    if (out_of_range(a)) return;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) shadow[a[AW+1:2]][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  bit          mon_en = 1'b0;
  bit          pend_cpu = 1'b0;
  bit          pend_host = 1'b0;
  logic [31:0] q_cpu[$];
  logic [31:0] q_host[$];

  always @(negedge clk) begin : scoreboard
    logic [31:0] e;
    if (mon_en) begin
      check_eq("cpu_rvld", {31'b0, cpu_if.rvld}, {31'b0, pend_cpu && !rst});
      if (pend_cpu) begin
        e = q_cpu.pop_front();
        if (cpu_if.rvld && !rst) check_eq("cpu_rdata", cpu_if.rdata, e);
      end
      check_eq("host_rvld", {31'b0, host_if.rvld}, {31'b0, pend_host && !rst});
      if (pend_host) begin
        e = q_host.pop_front();
        if (host_if.rvld && !rst) check_eq("host_rdata", host_if.rdata, e);
      end
      pend_cpu  = cpu_if.gnt && !cpu_if.we;
      pend_host = host_if.gnt && !host_if.we;
      if (pend_cpu) q_cpu.push_back(exp_read(cpu_if.addr));
      if (pend_host) q_host.push_back(exp_read(host_if.addr));
      if (cpu_if.gnt && cpu_if.we) shadow_write(cpu_if.addr, cpu_if.wdata, cpu_if.be);
      if (host_if.gnt && host_if.we) shadow_write(host_if.addr, host_if.wdata, host_if.be);
    end
  end

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] who, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    if (who[0]) begin
      cpu_if.req = 1'b1; cpu_if.we = we; cpu_if.addr = addr; cpu_if.wdata = wdata; cpu_if.be = be;
    end
    if (who[1]) begin
      host_if.req = 1'b1; host_if.we = we; host_if.addr = addr; host_if.wdata = wdata; host_if.be = be;
    end
  endtask

  // expected grant pattern under contention, 1 = CPU, MSB first
  task automatic grant_seq(input string tag, input int n, input logic [15:0] pat);
    logic [15:0] p;
    p = pat;
    for (int i = 0; i < n; i++) begin
      sample();
      check_eq({tag, "_cpu_gnt"}, {31'b0, cpu_if.gnt}, {31'b0, p[n-1-i]});
      check_eq({tag, "_host_gnt"}, {31'b0, host_if.gnt}, {31'b0, !p[n-1-i]});
      next();
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0; cpu_if.be = '0;
    host_if.req = 1'b0; host_if.we = 1'b0; host_if.addr = '0; host_if.wdata = '0; host_if.be = '0;
    drive(2'b01, 1'b0, 32'h100, 32'h0, 4'hF);
    drive(2'b10, 1'b0, 32'h200, 32'h0, 4'hF);
    next();
    mon_en = 1'b1;

    // both requesting while in reset: nothing may be issued
    repeat (2) begin
      sample();
      check_eq("rst_cpu_gnt", {31'b0, cpu_if.gnt}, 32'd0);
      check_eq("rst_host_gnt", {31'b0, host_if.gnt}, 32'd0);
      check_eq("rst_ram_en", {31'b0, ram_en}, 32'd0);
      check_eq("rst_err", {31'b0, err}, 32'd0);
      next();
    end
    rst = 1'b0;
    grant_seq("burst", 12, 16'b1111_0000_1111);

    // CPU write then read of 0x10
    host_if.req = 1'b0;
    drive(2'b01, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    sample();
    check_eq("wr_gnt", {31'b0, cpu_if.gnt}, 32'd1);
    check_eq("wr_ram_en", {31'b0, ram_en}, 32'd1);
    check_eq("wr_ram_we", {28'b0, ram_we}, 32'hF);
    check_eq("wr_ram_addr", {18'b0, ram_addr}, 32'd4);
    check_eq("wr_ram_wdata", ram_wdata, 32'hDEADBEEF);
    next();
    drive(2'b01, 1'b0, 32'h10, 32'h0, 4'hF);
    sample();
    check_eq("rd_ram_we", {28'b0, ram_we}, 32'h0);
    check_eq("rd_ram_addr", {18'b0, ram_addr}, 32'd4);
    next();

    // host read at N, CPU write at N+1
    cpu_if.req = 1'b0;
    drive(2'b10, 1'b0, 32'h10, 32'h0, 4'hF);
    sample();
    check_eq("hrd_gnt", {31'b0, host_if.gnt}, 32'd1);
    next();
    host_if.req = 1'b0;
    drive(2'b01, 1'b1, 32'h14, 32'h12345678, 4'hF);
    sample();
    check_eq("ovl_host_rvld", {31'b0, host_if.rvld}, 32'd1);
    check_eq("ovl_cpu_rvld", {31'b0, cpu_if.rvld}, 32'd0);
    check_eq("ovl_ram_we", {28'b0, ram_we}, 32'hF);
    check_eq("ovl_cpu_rdata_hold", cpu_if.rdata, 32'hDEADBEEF);
    next();
    drive(2'b01, 1'b1, 32'h10, 32'hCAFE5678, 4'h3);
    next();
    drive(2'b01, 1'b0, 32'h10, 32'h0, 4'hF);
    next();
    drive(2'b01, 1'b0, 32'h14, 32'h0, 4'hF);
    sample();
    check_eq("rd14_gnt", {31'b0, cpu_if.gnt}, 32'd1);
    next();

    // reset right after a CPU read grant drops the return
    rst = 1'b1;
    drive(2'b10, 1'b0, 32'h10, 32'h0, 4'hF);
    sample();
    check_eq("mid_rst_cpu_rvld", {31'b0, cpu_if.rvld}, 32'd0);
    check_eq("mid_rst_gnt", {31'b0, cpu_if.gnt | host_if.gnt}, 32'd0);
    next();
    rst = 1'b0;
    grant_seq("post_rst", 5, 16'b11110);

    // lone requesters move ownership, then contention resumes from the host's count
    host_if.req = 1'b0;
    grant_seq("solo_cpu", 1, 16'b1);
    cpu_if.req = 1'b0; host_if.req = 1'b1;
    grant_seq("solo_host", 2, 16'b00);
    cpu_if.req = 1'b1;
    grant_seq("resume", 4, 16'b0011);

    // upper address bits
    host_if.req = 1'b0;
    drive(2'b01, 1'b0, 32'h0001_0010, 32'h0, 4'hF);
    sample();
    check_eq("hi_gnt", {31'b0, cpu_if.gnt}, 32'd1);
`ifdef DRAM_ARB_RANGE_CHECK_EN
    check_eq("hi_ram_en", {31'b0, ram_en}, 32'd0);
`else
    check_eq("hi_ram_en", {31'b0, ram_en}, 32'd1);
    check_eq("hi_ram_addr", {18'b0, ram_addr}, 32'd4);
`endif
    next();
    cpu_if.req = 1'b0;
    repeat (2) begin
      sample();
`ifdef DRAM_ARB_RANGE_CHECK_EN
      check_eq("hi_err", {31'b0, err}, 32'd1);
`else
      check_eq("hi_err", {31'b0, err}, 32'd0);
`endif
      next();
    end
    rst = 1'b1;
    next();
    rst = 1'b0;
    sample();
    check_eq("err_cleared", {31'b0, err}, 32'd0);
    next();
    sample();
    check_eq("queues_drained", q_cpu.size() + q_host.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
